fir_decim: RTL and testbench
============================

# fir_decim

Audio-path decimating FIR filter sitting directly downstream of the FM demodulator. Pops Q10 demodulated samples from the demod output FIFO, shifts them into a TAPS-deep delay line, and for every DECIM samples consumed computes one multiply-accumulate pass over the programmable coefficient bank. Writes one filtered Q10 sample to the audio FIFO per pass. Implements the low-pass-and-decimate step between demodulation and the audio back end.

## Interface
- DATA_WIDTH, 32: sample, coefficient and accumulator width (signed, Q10).
- TAPS, 32: number of filter taps; power of two.
- DECIM, 8: input samples consumed per output sample; 1 ≤ DECIM ≤ TAPS.

- clk  in  1  sole clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- x_in  in  DATA_WIDTH  demod FIFO head (first-word-fall-through); valid while empty_x=0.
- empty_x  in  1  demod FIFO empty.
- rd_en_x  out  1  pop demod FIFO.
- y_out  out  DATA_WIDTH  filtered sample; meaningful only while wr_en_y=1, else 0.
- full_y  in  1  audio FIFO full.
- wr_en_y  out  1  push audio FIFO.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  log2(TAPS)  coefficient index.
- coef_data  in  DATA_WIDTH  coefficient value, signed Q10.
- coef_busy  out  1  high whenever state ≠ READ; coef_we ignored while high.

## Operation
- States: READ, MAC, WRITE. Reset → READ.
- READ: if empty_x=0, drive rd_en_x=1 (combinational, one cycle) and on that edge sr[k]←sr[k-1] for k=TAPS-1..1, sr[0]←x_in, cnt←cnt+1. When the captured sample makes cnt reach DECIM, cnt←0, acc←0, k←0, go to MAC; otherwise stay in READ.
- MAC: one tap per cycle: acc←acc+deq(coef[k]·sr[k]), k←k+1; after k=TAPS-1 go to WRITE. No FIFO reads.
- WRITE: if full_y=0, wr_en_y=1 and y_out=acc for that cycle; go to READ. If full_y=1, hold in WRITE with wr_en_y=0 and no reads.
- deq(p): full 2·DATA_WIDTH-bit signed product, arithmetic shift right 10 (rounding per Configuration), truncated to DATA_WIDTH. acc wraps modulo 2^DATA_WIDTH; no saturation.
- Coefficients: register bank, written on a clock edge when coef_we=1 and state=READ; ignored otherwise. A write in the same cycle as the DECIM-th read is accepted and used by the following MAC pass.
- Reset values (any time, including mid-MAC/WRITE): state READ, cnt 0, acc 0, sr all 0, coef all 0; rd_en_x=0, wr_en_y=0, y_out=0, coef_busy=0. A pass interrupted by reset is discarded; no write follows.

## Timing
- Read throughput: one sample per cycle while in READ and empty_x=0.
- Latency: DECIM-th rd_en_x in cycle t → MAC cycles t+1..t+TAPS → wr_en_y earliest in cycle t+TAPS+1.
- Output period ≥ max(DECIM, 1) + TAPS + 1 cycles under continuous input.
- full_y back-pressure stalls indefinitely; exactly one write per pass, never duplicated or dropped.
- empty_x gaps in READ only stall; cnt and sr retained.

## Configuration
- FIR_DECIM_ROUND_EN defined: deq adds 2^9 to the product before the >>>10 (round half up).
- Undefined: plain truncating arithmetic shift (round toward −∞). All other behaviour identical.

## Test plan
- Reset, all coef 0, push 8 samples of 1024 → one write, y_out=0, at 33 cycles after the 8th rd_en_x.
- coef[0]=1024, others 0; push x=n·1024 for n=0..15 → two writes: 7168 then 15360.
- All 32 coef=32; push 32 samples of 1024 → fourth write y_out=1024 (32 taps × 32).
- coef[0]=1; push 7 zeros then 512 → y_out=1 with FIR_DECIM_ROUND_EN, y_out=0 without.
- Hold full_y=1 for 5 cycles on entry to WRITE → wr_en_y=0 and rd_en_x=0 throughout; single write on release, next pass correct.
- Pulse coef_we (addr 0, data 2048) during MAC → coef_busy=1, write ignored, output unchanged; assert rst mid-MAC → all outputs 0, no write after release.

Source files
------------

// File: rtl/fir_decim.sv
// Decimating FIR: pops DECIM samples from the demod FIFO, then runs one TAPS-cycle MAC pass and pushes one Q10 result.
// Latency is TAPS+1 cycles from the DECIM-th pop to the earliest push. full_y stalls in WRITE. FIR_DECIM_ROUND_EN selects round-half-up dequantisation.
module fir_decim #(
  parameter int DATA_WIDTH = 32,
  parameter int TAPS       = 32,
  parameter int DECIM      = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_WIDTH-1:0]    x_in,
  input  logic                     empty_x,
  output logic                     rd_en_x,
  output logic [DATA_WIDTH-1:0]    y_out,
  input  logic                     full_y,
  output logic                     wr_en_y,
  input  logic                     coef_we,
  input  logic [$clog2(TAPS)-1:0]  coef_addr,
  input  logic [DATA_WIDTH-1:0]    coef_data,
  output logic                     coef_busy
);

  localparam int AW = $clog2(TAPS);
  localparam int CW = $clog2(DECIM + 1);

  typedef enum logic [1:0] {READ, MAC, WRITE} state_t;

  state_t                        state, state_nxt;
  logic signed [DATA_WIDTH-1:0]  sr   [TAPS];
  logic signed [DATA_WIDTH-1:0]  coef [TAPS];
  logic signed [DATA_WIDTH-1:0]  acc;
  logic [CW-1:0]                 cnt;
  logic [AW-1:0]                 k;
  logic                          last_read;
  logic signed [2*DATA_WIDTH-1:0] prod, prod_r;

`ifdef FIR_DECIM_ROUND_EN
  localparam logic signed [2*DATA_WIDTH-1:0] RND = (2*DATA_WIDTH)'(512);
`endif

  always_comb begin
    prod = (2*DATA_WIDTH)'(coef[k]) * (2*DATA_WIDTH)'(sr[k]);
`ifdef FIR_DECIM_ROUND_EN
    prod_r = prod + RND;
`else
    prod_r = prod;
`endif
  end

  always_comb begin
    state_nxt = state;
    rd_en_x   = 1'b0;
    wr_en_y   = 1'b0;
    y_out     = '0;
    last_read = 1'b0;
    case (state)
      READ: begin
        // Gated by rst so no pop is requested while reset is held.
        if (!empty_x && rst) begin
          rd_en_x = 1'b1;
          if (cnt == CW'(DECIM - 1)) begin
            last_read = 1'b1;
            state_nxt = MAC;
          end
        end
      end
      MAC: begin
        if (k == AW'(TAPS - 1)) state_nxt = WRITE;
      end
      WRITE: begin
        if (!full_y) begin
          wr_en_y   = 1'b1;
          y_out     = acc;
          state_nxt = READ;
        end
      end
      default: state_nxt = READ;
    endcase
  end

  assign coef_busy = (state != READ);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= READ;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      acc <= '0;
      k   <= '0;
      for (int i = 0; i < TAPS; i++) begin
        sr[i]   <= '0;
        coef[i] <= '0;
      end
    end else begin
      if (rd_en_x) begin
        for (int i = TAPS - 1; i > 0; i--) sr[i] <= sr[i-1];
        sr[0] <= x_in;
        cnt   <= last_read ? '0 : cnt + 1'b1;
      end
      if (last_read) begin
        acc <= '0;
        k   <= '0;
      end else if (state == MAC) begin
        // Product keeps bits [DATA_WIDTH+9:10]; accumulator wraps.
        acc <= acc + DATA_WIDTH'(prod_r >>> 10);
        k   <= k + 1'b1;
      end
      if (coef_we && state == READ) coef[coef_addr] <= coef_data;
    end
  end

endmodule

// File: tb/tb_fir_decim.sv
// Bench for fir_decim: directed sequence with random data, checked against a convolution model over the sample history.
module tb_fir_decim;
  localparam int W = 32;
  localparam int T = 32;
  localparam int D = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [W-1:0]  x_in = '0;
  logic          empty_x = 1'b1;
  logic          rd_en_x;
  logic [W-1:0]  y_out;
  logic          full_y = 1'b0;
  logic          wr_en_y;
  logic          coef_we = 1'b0;
  logic [4:0]    coef_addr = '0;
  logic [W-1:0]  coef_data = '0;
  logic          coef_busy;

  fir_decim #(.DATA_WIDTH(W), .TAPS(T), .DECIM(D)) dut (
    .clk(clk), .rst(rst), .x_in(x_in), .empty_x(empty_x), .rd_en_x(rd_en_x),
    .y_out(y_out), .full_y(full_y), .wr_en_y(wr_en_y), .coef_we(coef_we),
    .coef_addr(coef_addr), .coef_data(coef_data), .coef_busy(coef_busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int src[$];
  int hist[$];
  int expq[$];
  int mcoef[T];
  int mcnt = 0;
  bit awaiting = 0;
  int pend_cycle = 0;
  int gap_pct = 0;
  bit stall_req = 0;
  bit pulse_mac = 0;
  bit late_we = 0;
  int late_data = 0;
  bit req_we = 0;
  int req_addr = 0;
  int req_data = 0;
  int writes = 0;
  int last_y = 0;
  int last_lat = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  function automatic int deq(int c, int x);
    longint p;
    p = longint'(c) * longint'(x);
`ifdef FIR_DECIM_ROUND_EN
    p = p + 64'sd512;
`endif
    return int'(p >>> 10);
  endfunction

  // Output = sum over taps of deq(coef[k] * k-th most recent sample), older-than-reset samples are 0.
  function automatic int pass_value();
    int s = 0;
    int n = hist.size();
    for (int j = 0; j < T; j++)
      if (n - 1 - j >= 0) s += deq(mcoef[j], hist[n-1-j]);
    return s;
  endfunction

  task automatic step();
    bit busy_m;
    @(negedge clk);
    cyc++;
    busy_m  = awaiting;
    empty_x = (src.size() == 0) || ($urandom_range(99) < gap_pct);
    x_in    = empty_x ? $urandom : src[0];
    full_y  = stall_req && awaiting && (cyc - pend_cycle >= T + 1) && (cyc - pend_cycle < T + 6);
    coef_we = req_we;
    if (req_we) begin
      coef_addr = 5'(req_addr);
      coef_data = req_data;
    end
    req_we = 0;
    if (pulse_mac && awaiting && (cyc - pend_cycle == 5)) begin
      coef_we = 1; coef_addr = 0; coef_data = 2048;
    end
    if (late_we && !awaiting && !empty_x && mcnt == D - 1) begin
      coef_we = 1; coef_addr = 0; coef_data = late_data; late_we = 0;
    end
    #1;
    chk("coef_busy", coef_busy, busy_m);
    if (busy_m) begin
      chk("rd_en_busy", rd_en_x, 0);
      chk("wr_en", wr_en_y, (cyc - pend_cycle > T) && !full_y);
    end else begin
      chk("rd_en", rd_en_x, !empty_x);
      chk("wr_en_idle", wr_en_y, 0);
    end
    if (!wr_en_y) chk("y_idle", y_out, 0);
    else begin
      writes++;
      last_y   = int'(y_out);
      last_lat = cyc - pend_cycle;
      if (expq.size() == 0) chk("y_unexpected", wr_en_y, 0);
      else chk("y_out", y_out, expq.pop_front());
      awaiting = 0;
    end
    if (coef_we && !busy_m) mcoef[coef_addr] = int'(coef_data);
    if (!empty_x && !busy_m) begin
      hist.push_back(int'(x_in));
      void'(src.pop_front());
      mcnt++;
      if (mcnt == D) begin
        mcnt = 0;
        expq.push_back(pass_value());
        awaiting   = 1;
        pend_cycle = cyc;
      end
    end
  endtask

  task automatic write_coef(int a, int d);
    req_we = 1; req_addr = a; req_data = d;
    step();
  endtask

  task automatic run_until_idle(int budget);
    int n = 0;
    while ((src.size() > 0 || awaiting) && n < budget) begin
      step();
      n++;
    end
    chk("drain_in_budget", (n < budget), 1);
  endtask

  task automatic do_reset(int cycles);
    @(negedge clk);
    rst = 0; empty_x = 0; full_y = 0; coef_we = 0;
    #1;
    chk("rst_rd_en", rd_en_x, 0);
    chk("rst_wr_en", wr_en_y, 0);
    chk("rst_y_out", y_out, 0);
    chk("rst_busy", coef_busy, 0);
    hist.delete(); expq.delete(); src.delete();
    foreach (mcoef[i]) mcoef[i] = 0;
    mcnt = 0; awaiting = 0;
    repeat (cycles - 1) @(negedge clk);
    rst = 1; empty_x = 1;
  endtask

  initial begin
    int s8;
    int n;
    do_reset(3);

    // All-zero coefficients: one zero output, TAPS+1 cycles after the 8th pop.
    writes = 0;
    repeat (8) src.push_back(1024);
    run_until_idle(200);
    chk("zero_writes", writes, 1);
    chk("zero_y", last_y, 0);
    chk("latency", last_lat, T + 1);

    // Unit tap 0: outputs follow the newest sample.
    write_coef(0, 1024);
    writes = 0;
    for (int i = 0; i < 16; i++) src.push_back(i * 1024);
    run_until_idle(300);
    chk("unit_writes", writes, 2);
    chk("unit_last_y", last_y, 15360);

    // Flat 32-tap filter over a constant input.
    for (int a = 0; a < T; a++) write_coef(a, 32);
    writes = 0;
    repeat (32) src.push_back(1024);
    run_until_idle(600);
    chk("flat_writes", writes, 4);
    chk("flat_last_y", last_y, 1024);

    // Rounding boundary: deq(512) is exactly one half LSB.
    for (int a = 0; a < T; a++) write_coef(a, (a == 0) ? 1 : 0);
    writes = 0;
    repeat (7) src.push_back(0);
    src.push_back(512);
    run_until_idle(200);
    chk("round_writes", writes, 1);
`ifdef FIR_DECIM_ROUND_EN
    chk("round_y", last_y, 1);
`else
    chk("round_y", last_y, 0);
`endif

    // Random coefficients and samples with input gaps and 5-cycle back-pressure per pass.
    for (int a = 0; a < T; a++) write_coef(a, int'($urandom));
    gap_pct = 30;
    stall_req = 1;
    writes = 0;
    repeat (24) src.push_back(int'($urandom));
    run_until_idle(1000);
    chk("stall_writes", writes, 3);
    stall_req = 0;
    writes = 0;
    repeat (8) src.push_back(int'($urandom));
    run_until_idle(400);
    chk("post_stall_writes", writes, 1);

    // Coefficient write during MAC must be ignored by this and the next pass.
    gap_pct = 0;
    pulse_mac = 1;
    writes = 0;
    repeat (16) src.push_back(int'($urandom_range(4000)) - 2000);
    run_until_idle(400);
    pulse_mac = 0;
    chk("mac_we_writes", writes, 2);

    // Reset mid-MAC: pass discarded, nothing written afterwards.
    repeat (8) src.push_back(int'($urandom));
    n = 0;
    while (!(awaiting && cyc - pend_cycle >= 10) && n < 100) begin
      step();
      n++;
    end
    chk("reach_mac", awaiting, 1);
    do_reset(2);
    writes = 0;
    repeat (60) step();
    chk("no_write_after_rst", writes, 0);

    // Coefficient write coincident with the DECIM-th pop is used by that pass.
    late_we = 1;
    late_data = 1024;
    writes = 0;
    for (int i = 0; i < 8; i++) src.push_back(int'($urandom_range(1000000)) - 500000);
    s8 = src[7];
    run_until_idle(200);
    chk("late_writes", writes, 1);
    chk("late_coef_y", last_y, s8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
